filter_feeder: RTL

- Sample source for the `filter` block's input interface (`data` / `data_en`).
- A host loads signed samples into an internal FIFO.
- On `start`, the block drains the FIFO onto `data`/`data_en` as single-cycle strobes. Consecutive strobes are separated by a programmable number of idle cycles.
- Replaces hand-written strobe sequences in benches; it is also the on-chip driver in front of the filter.

---
 rtl/filter_feeder_if.sv | 33 +++
 rtl/filter_feeder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/filter_feeder_if.sv
// Host/filter-side bundle for filter_feeder: sample FIFO write port, run control
// and the data/data_en strobe stream, plus an FSM state debug tap.
interface filter_feeder_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int GAP_W  = 8
) ();
    // wr_en is a fire-and-forget strobe: a write is taken iff wr_en && !full
    // at the clock edge; there is no ready, a write while full is lost.
    logic                       wr_en;
    logic [DATA_W-1:0]          wr_data;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       start;
    logic                       stop;
    logic [GAP_W-1:0]           gap;
    logic [DATA_W-1:0]          data;
    logic                       data_en;
    logic                       busy;
    logic                       done;
    logic [1:0]                 dbg_state;

    modport master (
        output wr_en, wr_data, start, stop, gap,
        input  full, empty, count, data, data_en, busy, done, dbg_state
    );

    modport slave (
        input  wr_en, wr_data, start, stop, gap,
        output full, empty, count, data, data_en, busy, done, dbg_state
    );
endinterface

// File: rtl/filter_feeder.sv
// Sample FIFO plus a drain FSM that emits one-cycle data/data_en strobes spaced
// gap+1 cycles apart, feeding the filter input.
module filter_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int GAP_W  = 8
) (
    input logic            clk,
    input logic            rst,
    filter_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_WAIT = 2'd2} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full, r_empty;
    state_t            r_state, w_state_nxt;
    logic [GAP_W-1:0]  r_gap_q, w_gap_q_nxt;
    logic [GAP_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_data;
    logic              r_data_en, r_busy, r_done;
    logic              w_pop, w_done_nxt, w_wr_acc;
    logic [CW-1:0]     w_count_nxt;

    assign w_wr_acc    = bus.wr_en && !r_full;
    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_pop);

    // Storage is not reset; the pointers alone define what is held.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) r_mem[r_wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Each emission is decided one cycle ahead, so data/data_en come straight
    // out of flops; EMIT is the cycle the strobe is on the wire.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_gap_q_nxt = r_gap_q;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop && !r_empty) begin
                    w_gap_q_nxt = bus.gap;
                    w_pop       = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_q != '0) begin
                    w_cnt_nxt   = r_gap_q;
                    w_state_nxt = S_WAIT;
                end else if (!r_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt <= GAP_W'(1)) begin
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_q   <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_data_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_gap_q   <= w_gap_q_nxt;
            r_cnt     <= w_cnt_nxt;
            r_data    <= w_pop ? r_mem[r_rd_ptr] : '0;
            r_data_en <= w_pop;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.count     = r_count;
    assign bus.data      = r_data;
    assign bus.data_en   = r_data_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule
